// File: rtl/xnor3_pkg.sv
// Shared constants and the bitwise 3-input XNOR used by the xnor3_gate slice.
package xnor3_pkg;

  localparam int unsigned XNOR3_MAX_WIDTH  = 64;
  localparam int unsigned XNOR3_MAX_STAGES = 4;

  // Bitwise ~(a ^ b ^ c) at the widest legal width; callers size-cast the result.
  function automatic logic [XNOR3_MAX_WIDTH-1:0] xnor3_f(
    input logic [XNOR3_MAX_WIDTH-1:0] a,
    input logic [XNOR3_MAX_WIDTH-1:0] b,
    input logic [XNOR3_MAX_WIDTH-1:0] c
  );
    return ~(a ^ b ^ c);
  endfunction

endpackage

// File: rtl/xnor3_pipe_stage.sv
// One stage of the result pipeline: data register plus valid bit, both
// cleared by a synchronous active-high reset. Data loads every cycle.
module xnor3_pipe_stage
  import xnor3_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Capture data and validity on every edge; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/xnor3_gate.sv
// Bitwise 3-input XNOR with a zero-latency result and a valid-tagged copy
// delayed by PIPE_STAGES register stages.
module xnor3_gate
  import xnor3_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > XNOR3_MAX_WIDTH) begin : g_bad_width
    $error("xnor3_gate: WIDTH out of range 1..64");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > XNOR3_MAX_STAGES) begin : g_bad_stages
    $error("xnor3_gate: PIPE_STAGES out of range 1..4");
  end

  logic [WIDTH-1:0] stage_data  [PIPE_STAGES];
  logic             stage_valid [PIPE_STAGES];

  // The package function works at full width; the cast keeps only our bits.
  assign out = WIDTH'(xnor3_f(XNOR3_MAX_WIDTH'(a),
                              XNOR3_MAX_WIDTH'(b),
                              XNOR3_MAX_WIDTH'(c)));

  genvar i;
  for (i = 0; i < PIPE_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      xnor3_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .d       (out),
        .d_valid (in_valid),
        .q       (stage_data[0]),
        .q_valid (stage_valid[0])
      );
    end else begin : g_next
      xnor3_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .d       (stage_data[i-1]),
        .d_valid (stage_valid[i-1]),
        .q       (stage_data[i]),
        .q_valid (stage_valid[i])
      );
    end
  end

  assign out_q     = stage_data[PIPE_STAGES-1];
  assign out_valid = stage_valid[PIPE_STAGES-1];

endmodule

// File: tb/tb_xnor3_gate.sv
// Scoreboard bench for xnor3_gate: an 8-bit/3-stage instance and a
// 1-bit/4-stage instance share clock, reset and in_valid.
module tb_xnor3_gate;
  import xnor3_pkg::*;

  localparam int unsigned P8 = 3;
  localparam int unsigned P1 = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b, c;
  logic [7:0] out8, out_q8;
  logic       out_valid8;
  logic       out1, out_q1, out_valid1;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned s_edge = 0;
  int unsigned m_edge = 0;

  typedef struct {
    logic [7:0]  d;
    int unsigned due;
  } item_t;

  item_t q8[$];
  item_t q1[$];

  typedef struct {
    logic [7:0] a, b, c, e;
  } vec_t;

  // Hand-computed: abc sweep (a is MSB of index) then directed 8-bit words.
  vec_t vecs [12] = '{
    '{8'h00, 8'h00, 8'h00, 8'hFF},
    '{8'h00, 8'h00, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'h00, 8'h00, 8'h00},
    '{8'hFF, 8'h00, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'hFF, 8'hFF, 8'h00},
    '{8'hFF, 8'h0F, 8'h33, 8'h3C},
    '{8'hAA, 8'hAA, 8'hAA, 8'h55},
    '{8'h12, 8'h34, 8'h56, 8'h8F},
    '{8'hF0, 8'h0F, 8'h00, 8'h00}
  };

  xnor3_gate #(.WIDTH(8), .PIPE_STAGES(P8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out       (out8),
    .out_q     (out_q8),
    .out_valid (out_valid8)
  );

  xnor3_gate #(.WIDTH(1), .PIPE_STAGES(P1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a[0]),
    .b         (b[0]),
    .c         (c[0]),
    .out       (out1),
    .out_q     (out_q1),
    .out_valid (out_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, m_edge, act, exp);
    end
  endtask

  // Drive one cycle: inputs change at negedge, comb outputs checked 1 unit
  // later, expected registered results queued once the posedge samples them.
  task automatic step(input logic r, input logic v, input logic [7:0] ta,
                      input logic [7:0] tb, input logic [7:0] tc, input logic [7:0] exp8);
    item_t it;
    @(negedge clk);
    rst = r; in_valid = v; a = ta; b = tb; c = tc;
    #1;
    chk("comb8", out8, exp8);
    chk("comb1", 8'(out1), 8'(exp8[0]));
    @(posedge clk);
    s_edge++;
    if (r) begin
      q8.delete();
      q1.delete();
    end else if (v) begin
      it.d = exp8;              it.due = s_edge + P8 - 1; q8.push_back(it);
      it.d = 8'(exp8[0]);       it.due = s_edge + P1 - 1; q1.push_back(it);
    end
  endtask

  task automatic rnd_step(input logic r, input logic v);
    logic [7:0] ra, rb, rc;
    ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
    step(r, v, ra, rb, rc, 8'(xnor3_f(64'(ra), 64'(rb), 64'(rc))));
  endtask

  // Monitor: compare against the queue head when it is due, else expect idle.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      m_edge++;
      #1;
      if (rst) begin
        chk("rst_q8", out_q8, 8'h00);
        chk("rst_v8", 8'(out_valid8), 8'h00);
        chk("rst_q1", 8'(out_q1), 8'h00);
        chk("rst_v1", 8'(out_valid1), 8'h00);
      end else begin
        if (q8.size() > 0 && q8[0].due == m_edge) begin
          it = q8.pop_front();
          chk("valid8", 8'(out_valid8), 8'h01);
          chk("data8", out_q8, it.d);
        end else begin
          chk("idle8", 8'(out_valid8), 8'h00);
        end
        if (q1.size() > 0 && q1[0].due == m_edge) begin
          it = q1.pop_front();
          chk("valid1", 8'(out_valid1), 8'h01);
          chk("data1", 8'(out_q1), it.d);
        end else begin
          chk("idle1", 8'(out_valid1), 8'h00);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
    @(posedge clk);
    s_edge++;
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);

    // Directed vectors, back-to-back valid.
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);

    // Isolated single pulse, then quiet cycles.
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'hF0);

    // Reset in the middle of a continuous valid stream.
    for (int i = 0; i < 6; i++) rnd_step(1'b0, 1'b1);
    rnd_step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) rnd_step(1'b0, 1'b1);

    // Held reset: comb path keeps tracking, registered path stays cleared.
    for (int i = 0; i < 5; i++) rnd_step(1'b1, 1'b1);

    // Full-throughput random stream.
    for (int i = 0; i < 200; i++) rnd_step(1'b0, 1'b1);

    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);
    @(negedge clk);
    chk("drain8", 8'(q8.size()), 8'h00);
    chk("drain1", 8'(q1.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xnor3_gate.md
Name: xnor3_gate

Overview:
- Bitwise 3-input XNOR: out = ~(a ^ b ^ c), i.e. 1 when an even number of the three inputs are 1.
- Provides a combinational result plus a registered, valid-tagged copy delayed by a configurable number of pipeline stages.
- Used as a leaf logic primitive in datapaths that need an even-parity or equality-style term with timing isolation.

Parameters:
- WIDTH, 1, bit width of a, b, c and of both results; legal range 1..64.
- PIPE_STAGES, 1, number of register stages on the registered path; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock for all registers.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies a/b/c for the registered path.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c  in  WIDTH  operand C.
- out  out  WIDTH  combinational result ~(a ^ b ^ c), bitwise.
- out_q  out  WIDTH  registered result, delayed PIPE_STAGES cycles.
- out_valid  out  1  in_valid delayed PIPE_STAGES cycles; qualifies out_q.

Behaviour:
- Function per bit i: out[i] = ~(a[i] ^ b[i] ^ c[i]). Truth table for abc = 000..111: 1,0,0,1,0,1,1,0.
- out is purely combinational with zero latency. It is independent of clk, rst and in_valid, and updates whenever any input changes.
- Registered path is a shift chain of PIPE_STAGES stages. Stage 0 captures the XNOR of the current inputs; each later stage copies the previous one. out_q and out_valid are driven by the last stage.
- Data registers load every cycle regardless of in_valid; only out_valid carries validity. When out_valid = 0, out_q is don't-care for consumers, but the implementation must still follow the shift rule.
- Reset: while rst = 1 at a rising clk edge, every stage's data clears to 0 and every valid bit clears to 0. out_q and out_valid read 0 on the cycle after reset is sampled.
- Reset mid-stream flushes all in-flight results; nothing issued before reset ever appears with out_valid = 1.
- First valid output after reset deasserts: in_valid sampled at edge N appears on out_valid after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles of latency.
- Back-to-back in_valid every cycle gives full throughput, one result per cycle, with no bubbles and no backpressure.
- Inputs are never X-filtered; X on an input propagates per standard semantics.

Decomposition:
- Shared package xnor3_pkg holds:
  - constant XNOR3_MAX_WIDTH = 64;
  - constant XNOR3_MAX_STAGES = 4;
  - a function xnor3_f(a,b,c) returning the bitwise ~(a^b^c), reused by RTL and bench scoreboard.
- One sub-module, xnor3_pipe_stage: a WIDTH-bit data register plus a valid register with synchronous active-high clear. It is instantiated PIPE_STAGES times via generate.
- Top level contains the combinational XNOR, the generate chain, and elaboration-time parameter range checks.

Test Plan:
- WIDTH=1: sweep abc 000..111, 10 time units each -> out = 1,0,0,1,0,1,1,0; out_q matches each value PIPE_STAGES cycles later with out_valid=1.
- WIDTH=8: a=8'hFF, b=8'h0F, c=8'h33 -> out=8'h3C. Then a=b=c=8'hAA -> out=8'h55.
- PIPE_STAGES=3: single in_valid pulse at edge 5 with a=1,b=1,c=0 -> out_valid=1 only after edge 7, out_q=1; out_valid=0 on all other cycles.
- Reset mid-stream: PIPE_STAGES=4, in_valid=1 continuously, assert rst for one edge -> next cycle out_q=0 and out_valid=0; out_valid returns 4 cycles after rst drops.
- Throughput: random a/b/c for 200 back-to-back cycles with in_valid=1 -> out_q equals xnor3_f of the inputs delayed PIPE_STAGES cycles, zero mismatches.
- Comb independence: hold rst=1 and toggle inputs -> out still tracks ~(a^b^c) while out_q and out_valid stay 0.
